accumulate_unit: RTL and testbench
==================================

# accumulate_unit

Sequential accumulator stage wrapped around the 16-bit ripple-carry adder, `adder16`. It holds a 16-bit accumulator A and an operand register B. On a single `Execute` request it performs exactly one add or subtract, A ← A ± B, and writes the result back into A. It latches the carry and signed-overflow flags and counts completed operations. It sits between the switch/button front end (which feeds it) and the hex-display driver (which consumes `Aval`/`Bval`).

## Interface
Parameters:
- `WIDTH`, 16: datapath width. Must equal the `adder16` width; no other value is supported.
- `CNT_W`, 8: width of the operation counter.

Ports:
- `Clk`  in  1  single clock. All state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Din`  in  16  operand source for B.
- `LoadB`  in  1  level. In IDLE, B ← `Din` at the clock edge.
- `ClearA`  in  1  level. In IDLE, A ← 0 and both flags ← 0.
- `Execute`  in  1  level. Starts one operation from IDLE.
- `Sub`  in  1  sampled with `Execute`: 0 = add, 1 = subtract (A − B).
- `Aval`  out  16  accumulator register.
- `Bval`  out  16  operand register.
- `Cflag`  out  1  carry-out of the last operation. For subtract, 1 means no borrow.
- `Vflag`  out  1  two's-complement overflow of the last operation.
- `OpCount`  out  8  completed operations, modulo 256.
- `Busy`  out  1  high in COMPUTE.
- `Done`  out  1  high in DONE.

## Operation
- Reset (async, any state): state ← IDLE; `Aval`=0, `Bval`=0, `Cflag`=0, `Vflag`=0, `OpCount`=0, `sub_r`=0. `Busy`=0 and `Done`=0, since both decode from state.
- Adder inputs at all times: x = A, y = B XOR {16{`sub_r`}}, z = `sub_r`.
- Overflow: V = (x[15] == y[15]) && (S[15] != x[15]), using the post-inversion y.
- IDLE, priority when inputs are simultaneous: `ClearA` > `Execute` > `LoadB`.
  - `ClearA`: A ← 0, flags ← 0. Stay in IDLE; `Execute` and `LoadB` ignored that cycle.
  - `Execute`: `sub_r` ← `Sub`; go to COMPUTE. `LoadB` ignored that cycle.
  - `LoadB` only: B ← `Din`; stay in IDLE.
- COMPUTE, exactly one cycle:
  - A ← S, `Cflag` ← Cout, `Vflag` ← V, `OpCount` ← `OpCount` + 1 (wraps 255 → 0).
  - Go to DONE.
- DONE: hold all registers. Return to IDLE on the first edge where `Execute`=0. While `Execute` stays high, remain in DONE; no repeat operation.
- In COMPUTE and DONE, `LoadB`, `ClearA` and `Sub` are ignored.
- A and B may hold the same value; A − A gives 0 with `Cflag`=1 and `Vflag`=0.

## Timing
- `Execute` sampled high at edge n (state IDLE) → state=COMPUTE and `Busy`=1 after n.
- Edge n+1 → `Aval`, flags and `OpCount` are updated; `Busy`=0, `Done`=1.
- Latency from `Execute` sample to result visible: 2 edges.
- Minimum spacing between operations: 3 edges (COMPUTE, DONE, IDLE), with `Execute` low for at least 1 edge.
- The adder path (16-bit ripple) must close timing in one `Clk` period, from A/B/`sub_r` registers to the A/flag registers.
- `Busy`/`Done` are Moore outputs decoded from state; no combinational path from inputs.
- Reset asserted mid-COMPUTE: the in-flight result is discarded; all outputs take their reset values immediately, without waiting for a clock edge.

## Structure
- Package `accum_pkg`:
  - `state_t` enum {IDLE, COMPUTE, DONE}, 2-bit.
  - Constants `ACC_W`=16 and `CNT_W`=8.
- One sub-module: instance of `adder16` (ports x/y/z/s/c per bit are internal to it; top-level connection A/B/Cin/S/Cout).
- No other hierarchy. Operand inversion, overflow detect, registers and FSM live in `accumulate_unit`.

## Test plan
- Reset values: assert `Reset` with random prior state → `Aval`=0x0000, `Bval`=0x0000, `Cflag`=0, `Vflag`=0, `OpCount`=0, `Busy`=0, `Done`=0.
- Add with carry: A=0xFFFF (reached via load-and-add from 0), LoadB 0x0001, Execute with `Sub`=0 → after 2 edges `Aval`=0x0000, `Cflag`=1, `Vflag`=0, `Done`=1.
- Signed overflow: A=0x7FFF, B=0x0001, add → `Aval`=0x8000, `Cflag`=0, `Vflag`=1.
- Subtract with borrow: A=0x0005, B=0x0007, `Sub`=1 → `Aval`=0xFFFE, `Cflag`=0, `Vflag`=0. Then A=0x8000, B=0x0001, subtract → `Aval`=0x7FFF, `Vflag`=1.
- Handshake: hold `Execute` high 10 cycles with A=0, B=0x0003 → `Aval`=0x0003 (one operation only), `OpCount`=1, `Done` high until `Execute` drops. Simultaneous `ClearA` + `Execute` in IDLE → A=0, no operation, `OpCount` unchanged.
- Reset and wrap:
  - Assert `Reset` while `Busy`=1 → `Aval`=0, `OpCount`=0, state IDLE.
  - Separately, run 256 operations → `OpCount` wraps to 0x00.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator stage.
package accum_pkg;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/accumulate_unit_adder16.sv
// 16-bit ripple-carry adder built from a chain of full-adder cells.
module adder16
    import accum_pkg::*;
(
    input  logic [ACC_W-1:0] A,
    input  logic [ACC_W-1:0] B,
    input  logic             Cin,
    output logic [ACC_W-1:0] S,
    output logic             Cout
);

    logic [ACC_W:0] w_c;

    assign w_c[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < ACC_W; gi++) begin : g_fa
            logic w_x, w_y, w_z;
            assign w_x       = A[gi];
            assign w_y       = B[gi];
            assign w_z       = w_c[gi];
            assign S[gi]     = w_x ^ w_y ^ w_z;
            assign w_c[gi+1] = (w_x & w_y) | (w_x & w_z) | (w_y & w_z);
        end
    endgenerate

    assign Cout = w_c[ACC_W];

endmodule

// File: rtl/accumulate_unit.sv
// Accumulator stage: one A <= A +/- B per Execute request, with latched
// carry/overflow flags and a completed-operation counter.
module accumulate_unit
    import accum_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             LoadB,
    input  logic             ClearA,
    input  logic             Execute,
    input  logic             Sub,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Cflag,
    output logic             Vflag,
    output logic [CNT_W-1:0] OpCount,
    output logic             Busy,
    output logic             Done
);

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b;
    logic               r_c, r_v, r_sub;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_y, w_s;
    logic               w_cout, w_v;

    // Subtract is A + ~B + 1: invert the operand and inject the carry.
    assign w_y = r_b ^ {WIDTH{r_sub}};

    adder16 u_adder (
        .A    (r_a),
        .B    (w_y),
        .Cin  (r_sub),
        .S    (w_s),
        .Cout (w_cout)
    );

    // Overflow judged on the post-inversion operand so add and subtract share one rule.
    assign w_v = (r_a[WIDTH-1] == w_y[WIDTH-1]) && (w_s[WIDTH-1] != r_a[WIDTH-1]);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: ClearA blocks Execute in IDLE; DONE waits for Execute to drop.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!ClearA && Execute) w_next = COMPUTE;
            COMPUTE: w_next = DONE;
            DONE:    if (!Execute) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers: IDLE takes commands, COMPUTE commits the result.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_sub <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ClearA) begin
                        r_a <= '0;
                        r_c <= 1'b0;
                        r_v <= 1'b0;
                    end else if (Execute) begin
                        r_sub <= Sub;
                    end else if (LoadB) begin
                        r_b <= Din;
                    end
                end
                COMPUTE: begin
                    r_a   <= w_s;
                    r_c   <= w_cout;
                    r_v   <= w_v;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Aval    = r_a;
    assign Bval    = r_b;
    assign Cflag   = r_c;
    assign Vflag   = r_v;
    assign OpCount = r_cnt;
    assign Busy    = (r_state == COMPUTE);
    assign Done    = (r_state == DONE);

endmodule

// File: tb/tb_accumulate_unit.sv
// Directed bench for accumulate_unit: vector table of load/execute operations
// plus hand-written handshake, clear-priority, reset and wrap sequences.
module tb_accumulate_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] Din = '0;
    logic        LoadB = 1'b0, ClearA = 1'b0, Execute = 1'b0, Sub = 1'b0;
    logic [15:0] Aval, Bval;
    logic        Cflag, Vflag, Busy, Done;
    logic [7:0]  OpCount;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    accumulate_unit dut (
        .Clk(Clk), .Reset(Reset), .Din(Din), .LoadB(LoadB), .ClearA(ClearA),
        .Execute(Execute), .Sub(Sub), .Aval(Aval), .Bval(Bval), .Cflag(Cflag),
        .Vflag(Vflag), .OpCount(OpCount), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        clr;
        logic [15:0] b;
        logic        sub;
        logic [15:0] exp_a;
        logic        exp_c;
        logic        exp_v;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic clear_a();
        ClearA = 1'b1; tick(); ClearA = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v);
        Din = v; LoadB = 1'b1; tick(); LoadB = 1'b0;
    endtask

    // Full operation with exact-latency checks on Busy and Done.
    task automatic run_op(input logic s, input bit chk);
        Execute = 1'b1; Sub = s;
        tick();
        if (chk) check("busy_after_exec", {31'd0, Busy}, 32'd1);
        tick();
        exp_cnt = (exp_cnt + 1) % 256;
        if (chk) begin
            check("done_after_2", {31'd0, Done}, 32'd1);
            check("busy_low_done", {31'd0, Busy}, 32'd0);
        end
        Execute = 1'b0; Sub = 1'b0;
        tick();
        if (chk) check("done_low_idle", {31'd0, Done}, 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1; #1;
        check("rst_aval", {16'd0, Aval}, 32'd0);
        check("rst_bval", {16'd0, Bval}, 32'd0);
        check("rst_flags", {30'd0, Cflag, Vflag}, 32'd0);
        check("rst_opcount", {24'd0, OpCount}, 32'd0);
        check("rst_busy_done", {30'd0, Busy, Done}, 32'd0);
        exp_cnt = 0;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    initial begin
        //          clr   b         sub   exp_a     c     v
        vecs[0] = '{1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 1'b0};

        @(negedge Clk);
        // Put some state in first so reset has something to clear.
        load_b(16'h1234);
        run_op(1'b0, 1'b0);
        do_reset();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].clr) clear_a();
            load_b(vecs[i].b);
            check($sformatf("v%0d_bval", i), {16'd0, Bval}, {16'd0, vecs[i].b});
            run_op(vecs[i].sub, 1'b1);
            check($sformatf("v%0d_aval", i), {16'd0, Aval}, {16'd0, vecs[i].exp_a});
            check($sformatf("v%0d_cflag", i), {31'd0, Cflag}, {31'd0, vecs[i].exp_c});
            check($sformatf("v%0d_vflag", i), {31'd0, Vflag}, {31'd0, vecs[i].exp_v});
            check($sformatf("v%0d_opcount", i), {24'd0, OpCount}, exp_cnt);
        end

        // Execute held high: exactly one add, Done held until release.
        clear_a();
        check("clr_flags", {30'd0, Cflag, Vflag}, 32'd0);
        load_b(16'h0003);
        Execute = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k >= 1) check($sformatf("hold_done_%0d", k), {31'd0, Done}, 32'd1);
        end
        exp_cnt = (exp_cnt + 1) % 256;
        check("hold_aval", {16'd0, Aval}, 32'h0003);
        check("hold_opcount", {24'd0, OpCount}, exp_cnt);
        Execute = 1'b0;
        tick();
        check("hold_release", {31'd0, Done}, 32'd0);

        // ClearA wins over Execute and LoadB.
        ClearA = 1'b1; Execute = 1'b1; LoadB = 1'b1; Din = 16'hBEEF;
        tick();
        ClearA = 1'b0; Execute = 1'b0; LoadB = 1'b0;
        check("clrexe_aval", {16'd0, Aval}, 32'd0);
        check("clrexe_busy", {31'd0, Busy}, 32'd0);
        check("clrexe_bval", {16'd0, Bval}, 32'h0003);
        tick();
        check("clrexe_opcount", {24'd0, OpCount}, exp_cnt);
        check("clrexe_done", {31'd0, Done}, 32'd0);

        // Reset while in COMPUTE: outputs clear without a clock edge.
        Execute = 1'b1;
        tick();
        check("mid_busy", {31'd0, Busy}, 32'd1);
        Execute = 1'b0;
        do_reset();
        tick();
        check("mid_idle_done", {30'd0, Busy, Done}, 32'd0);

        // 256 unit adds: counter wraps, A counts up to 0x0100.
        load_b(16'h0001);
        for (int k = 0; k < 255; k++) run_op(1'b0, 1'b0);
        check("wrap_255", {24'd0, OpCount}, 32'd255);
        run_op(1'b0, 1'b0);
        check("wrap_opcount", {24'd0, OpCount}, exp_cnt);
        check("wrap_zero", {24'd0, OpCount}, 32'd0);
        check("wrap_aval", {16'd0, Aval}, 32'h0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
